// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, constants and types for the instruction-fetch stage
// Purpose : single home for fetch-stage widths, reset/NOP/HALT encodings and types.
// Contents: PC_W, INSTR_W, RESET_PC, NOP_INSTR, HALT_INSTR, pc_t, instr_t,
//           if_state_t, pc_inc2() helper (PC + 2, wraps modulo 2^PC_W).
package fetch_pkg;

  localparam int              PC_W       = 8;
  localparam int              INSTR_W    = 16;
  localparam logic [PC_W-1:0] RESET_PC   = 8'h00;
  localparam logic [15:0]     NOP_INSTR  = 16'h0000;
  localparam logic [15:0]     HALT_INSTR = 16'hEFFF;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic {
    IF_RUN  = 1'b0,
    IF_HALT = 1'b1
  } if_state_t;

  // Sequential fetch step; overflow wraps silently (FE + 2 -> 00).
  function automatic pc_t pc_inc2(input pc_t pc);
    return pc + pc_t'(2);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bus: imem port, pipeline control and IF/ID outputs
// Purpose : bundles every non-clock/reset signal of if_stage.
// Signals : imem_addr/imem_instr      instruction memory (combinational read)
//           stall/flush/redirect_*    pipeline control from later stages
//           ifid_*                    IF/ID pipeline register contents
//           halted                    fetch stopped on HALT word
// Modports: master = fetch stage, slave = surrounding core / memory.
interface if_stage_if;
  import fetch_pkg::*;

  pc_t    imem_addr;
  instr_t imem_instr;
  logic   stall;
  logic   flush;
  logic   redirect_valid;
  pc_t    redirect_target;
  instr_t ifid_instr;
  pc_t    ifid_pc;
  pc_t    ifid_pc_plus2;
  logic   ifid_valid;
  logic   halted;

  modport master (
    output imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, halted,
    input  imem_instr, stall, flush, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, halted,
    output imem_instr, stall, flush, redirect_valid, redirect_target
  );

endinterface

// File: rtl/if_pc_gen.sv
// rtl/if_pc_gen.sv - program counter register and next-PC selection
// Purpose : holds the PC and picks its next value.
//           Priority: redirect > (stall | hold) > sequential +2.
// Ports   : clk, rst_n              clock, async active-low reset
//           redirect_valid_i        load PC from redirect_target_i (bit 0 cleared)
//           redirect_target_i       branch/jump destination
//           stall_i                 hold PC this cycle
//           hold_i                  hold PC because fetch is (or is becoming) halted
//           pc_o                    current PC
module if_pc_gen
  import fetch_pkg::*;
#(
  parameter pc_t RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic redirect_valid_i,
  input  pc_t  redirect_target_i,
  input  logic stall_i,
  input  logic hold_i,
  output pc_t  pc_o
);

  // Instructions are halfword aligned, so the PC is kept even in every path.
  localparam pc_t EVEN_MASK = ~pc_t'(1);

  pc_t pc_q;
  pc_t pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = redirect_target_i & EVEN_MASK;
    end else if (stall_i || hold_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_inc2(pc_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC & EVEN_MASK;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC, imem address, IF/ID register, halt FSM
// Purpose : fetches one 16-bit word per cycle from a combinational instruction memory
//           and registers it into IF/ID. Handles stall, flush and redirect.
// Config  : IF_HALT_DETECT_EN - when defined, fetching HALT_INSTR stops fetch (IF_HALT)
//           until a redirect; otherwise the FSM stays in IF_RUN and halted is 0.
// Ports   : clk    core clock
//           rst_n  asynchronous active-low reset
//           bus    if_stage_if.master (imem_addr/imem_instr, stall, flush,
//                  redirect_valid/redirect_target, ifid_*, halted)
module if_stage
  import fetch_pkg::*;
#(
  parameter pc_t RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);

  pc_t    pc;
  logic   in_halt;   // FSM is in IF_HALT
  logic   halt_hit;  // this edge captures the HALT word on the normal path

  instr_t ifid_instr_q, ifid_instr_d;
  pc_t    ifid_pc_q, ifid_pc_d;
  pc_t    ifid_pc_plus2_q, ifid_pc_plus2_d;
  logic   ifid_valid_q, ifid_valid_d;

  // The PC also freezes on the edge that captures HALT, so imem_addr stays on it.
  if_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk               (clk),
    .rst_n             (rst_n),
    .redirect_valid_i  (bus.redirect_valid),
    .redirect_target_i (bus.redirect_target),
    .stall_i           (bus.stall),
    .hold_i            (in_halt || halt_hit),
    .pc_o              (pc)
  );

`ifdef IF_HALT_DETECT_EN
  if_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    halt_hit = 1'b0;
    case (state_q)
      IF_RUN: begin
        if (!bus.redirect_valid && !bus.stall && !bus.flush &&
            (bus.imem_instr == HALT_INSTR)) begin
          halt_hit = 1'b1;
          state_d  = IF_HALT;
        end
      end
      IF_HALT: begin
        if (bus.redirect_valid) begin
          state_d = IF_RUN;
        end
      end
      default: state_d = IF_RUN;
    endcase
  end

  assign in_halt = (state_q == IF_HALT);
`else
  assign in_halt  = 1'b0;
  assign halt_hit = 1'b0;
`endif

  // IF/ID next state. The HALT word itself goes through the normal path, so it is
  // presented once; afterwards the halted branch keeps issuing bubbles.
  always_comb begin
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus2_d = ifid_pc_plus2_q;
    ifid_valid_d    = ifid_valid_q;
    if (bus.redirect_valid) begin
      ifid_valid_d = 1'b0;
    end else if (in_halt) begin
      ifid_valid_d = 1'b0;
    end else if (bus.stall) begin
      ifid_valid_d = ifid_valid_q;
    end else if (bus.flush) begin
      ifid_valid_d = 1'b0;
    end else begin
      ifid_instr_d    = bus.imem_instr;
      ifid_pc_d       = pc;
      ifid_pc_plus2_d = pc_inc2(pc);
      ifid_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_q       <= '0;
      ifid_pc_plus2_q <= '0;
      ifid_valid_q    <= 1'b0;
    end else begin
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus2_q <= ifid_pc_plus2_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

  assign bus.imem_addr     = pc;
  assign bus.ifid_instr    = ifid_instr_q;
  assign bus.ifid_pc       = ifid_pc_q;
  assign bus.ifid_pc_plus2 = ifid_pc_plus2_q;
  assign bus.ifid_valid    = ifid_valid_q;
  assign bus.halted        = in_halt;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage (two instances, RESET_PC 00 and FC)
module tb_if_stage;

`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [7:0]  ipc;
    logic [7:0]  pp2;
    logic        valid;
    logic        halted;
    logic        full;   // reset state: every IF/ID field is defined
  } mst_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       rv = 1'b0;
  logic [7:0] rt = 8'h00;

  int total = 0;
  int bad = 0;

  mst_t m0, m1;
  mst_t sb0[$];
  mst_t sb1[$];

  always #5 clk = ~clk;

  if_stage_if bus0();
  if_stage_if bus1();

  // Bench memory: word at A is {A5, A}, except a HALT word planted at 0x10.
  function automatic logic [15:0] mem(input logic [7:0] a);
    return (a == 8'h10) ? 16'hEFFF : {8'hA5, a};
  endfunction

  assign bus0.imem_instr      = mem(bus0.imem_addr);
  assign bus0.stall           = stall;
  assign bus0.flush           = flush;
  assign bus0.redirect_valid  = rv;
  assign bus0.redirect_target = rt;
  assign bus1.imem_instr      = mem(bus1.imem_addr);
  assign bus1.stall           = stall;
  assign bus1.flush           = flush;
  assign bus1.redirect_valid  = rv;
  assign bus1.redirect_target = rt;

  if_stage #(.RESET_PC(8'h00)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  if_stage #(.RESET_PC(8'hFC)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  function automatic mst_t reset_state(input logic [7:0] rpc);
    mst_t r;
    r.pc = rpc; r.instr = 16'h0000; r.ipc = 8'h00; r.pp2 = 8'h00;
    r.valid = 1'b0; r.halted = 1'b0; r.full = 1'b1;
    return r;
  endfunction

  // Reference: what the fetch stage should hold after one clock edge.
  function automatic mst_t model_next(input mst_t s, input logic [7:0] rpc);
    mst_t n;
    logic [15:0] w;
    n = s;
    n.full = 1'b0;
    if (!rst_n) return reset_state(rpc);
    if (rv) begin
      n.pc = rt & 8'hFE; n.valid = 1'b0; n.halted = 1'b0;
    end else if (s.halted) begin
      n.valid = 1'b0;
    end else if (stall) begin
      n.valid = s.valid;
    end else if (flush) begin
      n.pc = s.pc + 8'd2; n.valid = 1'b0;
    end else begin
      w = mem(s.pc);
      n.instr = w; n.ipc = s.pc; n.pp2 = s.pc + 8'd2; n.valid = 1'b1;
      if (HALT_EN && w == 16'hEFFF) n.halted = 1'b1;
      else n.pc = s.pc + 8'd2;
    end
    return n;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk(input int k, input mst_t e, input logic [7:0] addr,
                     input logic [15:0] instr, input logic [7:0] ipc, input logic [7:0] pp2,
                     input logic valid, input logic halted);
    cmp($sformatf("dut%0d.imem_addr", k), {8'h00, addr}, {8'h00, e.pc});
    cmp($sformatf("dut%0d.ifid_valid", k), {15'h0, valid}, {15'h0, e.valid});
    cmp($sformatf("dut%0d.halted", k), {15'h0, halted}, {15'h0, e.halted});
    if (e.valid || e.full) begin
      cmp($sformatf("dut%0d.ifid_instr", k), instr, e.instr);
      cmp($sformatf("dut%0d.ifid_pc", k), {8'h00, ipc}, {8'h00, e.ipc});
      cmp($sformatf("dut%0d.ifid_pc_plus2", k), {8'h00, pp2}, {8'h00, e.pp2});
    end
  endtask

  // Monitor: one expectation per edge, compared mid-cycle.
  always @(negedge clk) begin
    mst_t e;
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      chk(0, e, bus0.imem_addr, bus0.ifid_instr, bus0.ifid_pc, bus0.ifid_pc_plus2,
          bus0.ifid_valid, bus0.halted);
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      chk(1, e, bus1.imem_addr, bus1.ifid_instr, bus1.ifid_pc, bus1.ifid_pc_plus2,
          bus1.ifid_valid, bus1.halted);
    end
  end

  task automatic step();
    m0 = model_next(m0, 8'h00);
    m1 = model_next(m1, 8'hFC);
    @(posedge clk);
    sb0.push_back(m0);
    sb1.push_back(m1);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [7:0] t,
                       input int n);
    stall = s; flush = f; rv = r; rt = t;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    m0 = reset_state(8'h00);
    m1 = reset_state(8'hFC);
    // Reset held, then released away from the edge.
    drive(0, 0, 0, 8'h00, 2);
    rst_n = 1'b1;
    // Sequential fetch, then a 3-cycle stall at pc 06.
    drive(0, 0, 0, 8'h00, 3);
    drive(1, 0, 0, 8'h00, 3);
    drive(0, 0, 0, 8'h00, 2);
    // Redirect to odd target 31, then redirect together with stall.
    drive(0, 0, 1, 8'h31, 1);
    drive(0, 0, 0, 8'h00, 2);
    drive(1, 0, 1, 8'h31, 1);
    drive(0, 0, 0, 8'h00, 2);
    // Flush, flush with stall, then normal.
    drive(0, 1, 0, 8'h00, 1);
    drive(1, 1, 0, 8'h00, 2);
    drive(0, 0, 0, 8'h00, 2);
    // Walk over the HALT word at 0x10, stall while there, then redirect to 20.
    drive(0, 0, 1, 8'h0C, 1);
    drive(0, 0, 0, 8'h00, 4);
    drive(1, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 8'h00, 2);
    drive(0, 0, 1, 8'h20, 1);
    drive(0, 0, 0, 8'h00, 3);
    // PC wrap from FC.
    drive(0, 0, 1, 8'hFD, 1);
    drive(0, 0, 0, 8'h00, 4);
    // Asynchronous reset mid-stream with flush high.
    #2;
    flush = 1'b1;
    rst_n = 1'b0;
    #1;
    sb0.delete();
    sb1.delete();
    m0 = reset_state(8'h00);
    m1 = reset_state(8'hFC);
    chk(0, m0, bus0.imem_addr, bus0.ifid_instr, bus0.ifid_pc, bus0.ifid_pc_plus2,
        bus0.ifid_valid, bus0.halted);
    chk(1, m1, bus1.imem_addr, bus1.ifid_instr, bus1.ifid_pc, bus1.ifid_pc_plus2,
        bus1.ifid_valid, bus1.halted);
    @(posedge clk);
    #1;
    drive(0, 1, 0, 8'h00, 2);
    rst_n = 1'b1;
    drive(0, 0, 0, 8'h00, 3);
    // Randomized control traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, 8'($urandom_range(0, 255)), 1);
    end
    drive(0, 0, 0, 8'h00, 2);
    @(negedge clk);
    #1;
    total++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", sb0.size(), sb1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
